// File: rtl/memory_access_pkg.sv
// rtl/memory_access_pkg.sv - shared types for the memory-access pipeline stage
package memory_access_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE     = 2'd0,
    MEM_HALF     = 2'd1,
    MEM_WORD     = 2'd2,
    MEM_WORD_ALT = 2'd3
  } MemAccessWidth;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } MemState;

  localparam int RD_CTRL_WE_BIT = 6;

  typedef struct packed {
    logic [31:0]   pc;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    MemAccessWidth width;
    logic          is_load;
    logic          is_store;
    logic          is_unsigned;
    logic [6:0]    rd_ctrl;
  } MemoryAccessStagePipeReg;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  rd_ctrl;
    logic [31:0] data;
  } WriteBackStagePipeReg;

  function automatic logic is_misaligned(input MemAccessWidth w, input logic [1:0] lo);
    case (w)
      MEM_BYTE: return 1'b0;
      MEM_HALF: return lo[0];
      default:  return lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/memory_access_load_store_aligner.sv
// rtl/memory_access_load_store_aligner.sv - store lane placement and load extraction/extension
module load_store_aligner
  import memory_access_pkg::*;
(
  input  logic [1:0]    i_addr_lo,
  input  MemAccessWidth i_width,
  input  logic          i_unsigned,
  input  logic [31:0]   i_wdata,
  input  logic [31:0]   i_rdata,
  output logic [3:0]    o_byte_en,
  output logic [31:0]   o_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] w_shifted;

  assign w_shifted = i_rdata >> {i_addr_lo, 3'b000};

  always_comb begin
    o_byte_en = 4'b1111;
    o_wdata   = i_wdata;
    o_rdata   = w_shifted;
    case (i_width)
      MEM_BYTE: begin
        o_byte_en = 4'b0001 << i_addr_lo;
        o_wdata   = {4{i_wdata[7:0]}};
        o_rdata   = i_unsigned ? {24'd0, w_shifted[7:0]}
                               : {{24{w_shifted[7]}}, w_shifted[7:0]};
      end
      MEM_HALF: begin
        o_byte_en = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata   = {2{i_wdata[15:0]}};
        o_rdata   = i_unsigned ? {16'd0, w_shifted[15:0]}
                               : {{16{w_shifted[15]}}, w_shifted[15:0]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// rtl/memory_access.sv - memory-access stage: issues data-memory requests, waits for ack, writes back
module memory_access
  import memory_access_pkg::*;
#(
  parameter int DMEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] exPc,
  input  logic [31:0] exAluResult,
  input  logic [31:0] exWData,
  input  logic [1:0]  exMemAccessWidth,
  input  logic        exIsLoad,
  input  logic        exIsStore,
  input  logic        exIsLoadUnsigned,
  input  logic [6:0]  exRdCtrl,
  output logic        dmemReq,
  output logic        dmemWe,
  output logic [31:0] dmemAddr,
  output logic [3:0]  dmemByteEn,
  output logic [31:0] dmemWData,
  input  logic        dmemAck,
  input  logic [31:0] dmemRData,
  output logic        stall,
  output logic        misaligned,
  output logic        busError,
  output logic [31:0] wbPc,
  output logic [6:0]  wbRdCtrl,
  output logic [31:0] wbData
);

  localparam int CW = $clog2(DMEM_TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(DMEM_TIMEOUT - 1);

  MemState                 r_state;
  logic [CW-1:0]           r_cnt;
  MemoryAccessStagePipeReg r_req;
  WriteBackStagePipeReg    r_wb;
  logic                    r_misaligned;
  logic                    r_bus_error;

  MemoryAccessStagePipeReg w_ex;
  logic                    w_is_mem;
  logic                    w_misaligned;
  logic                    w_in_wait;
  logic [3:0]              w_byte_en;
  logic [31:0]             w_wdata;
  logic [31:0]             w_load_data;

  assign w_ex = '{pc: exPc, addr: exAluResult, wdata: exWData,
                  width: MemAccessWidth'(exMemAccessWidth), is_load: exIsLoad,
                  is_store: exIsStore, is_unsigned: exIsLoadUnsigned, rd_ctrl: exRdCtrl};
  assign w_is_mem     = exIsLoad | exIsStore;
  assign w_misaligned = is_misaligned(w_ex.width, exAluResult[1:0]);
  assign w_in_wait    = (r_state == MEM_WAIT);

  load_store_aligner u_aligner (
    .i_addr_lo  (r_req.addr[1:0]),
    .i_width    (r_req.width),
    .i_unsigned (r_req.is_unsigned),
    .i_wdata    (r_req.wdata),
    .i_rdata    (dmemRData),
    .o_byte_en  (w_byte_en),
    .o_wdata    (w_wdata),
    .o_rdata    (w_load_data)
  );

  // The request bus is driven purely from the latched access, so it is quiet in IDLE and after reset.
  assign dmemReq    = w_in_wait;
  assign dmemWe     = w_in_wait & r_req.is_store;
  assign dmemAddr   = w_in_wait ? {r_req.addr[31:2], 2'b00} : 32'd0;
  assign dmemByteEn = w_in_wait ? w_byte_en : 4'd0;
  assign dmemWData  = w_in_wait ? w_wdata : 32'd0;

  always_comb begin
    stall = 1'b0;
    if (w_in_wait) stall = ~dmemAck;
    else           stall = w_is_mem & ~w_misaligned;
  end

  assign misaligned = r_misaligned;
  assign busError   = r_bus_error;
  assign wbPc       = r_wb.pc;
  assign wbRdCtrl   = r_wb.rd_ctrl;
  assign wbData     = r_wb.data;

  always_ff @(negedge clk) begin
    if (!rst) begin
      r_state      <= MEM_IDLE;
      r_cnt        <= '0;
      r_req        <= '0;
      r_wb         <= '0;
      r_misaligned <= 1'b0;
      r_bus_error  <= 1'b0;
    end else begin
      r_misaligned <= 1'b0;
      r_bus_error  <= 1'b0;
      case (r_state)
        MEM_IDLE: begin
          r_wb.pc      <= exPc;
          r_wb.rd_ctrl <= exRdCtrl;
          r_wb.data    <= exAluResult;
          if (w_is_mem) begin
            r_wb.rd_ctrl[RD_CTRL_WE_BIT] <= 1'b0;
            if (w_misaligned) begin
              r_misaligned <= 1'b1;
            end else begin
              r_req   <= w_ex;
              r_cnt   <= '0;
              r_state <= MEM_WAIT;
            end
          end
        end
        MEM_WAIT: begin
          if (dmemAck) begin
            r_wb.pc      <= r_req.pc;
            r_wb.rd_ctrl <= r_req.rd_ctrl;
            r_wb.data    <= r_req.is_load ? w_load_data : r_req.addr;
            if (r_req.is_store) r_wb.rd_ctrl[RD_CTRL_WE_BIT] <= 1'b0;
            r_state <= MEM_IDLE;
          end else if (r_cnt == LIMIT) begin
            r_wb.rd_ctrl[RD_CTRL_WE_BIT] <= 1'b0;
            r_bus_error <= 1'b1;
            r_state     <= MEM_IDLE;
          end else begin
            r_wb.rd_ctrl[RD_CTRL_WE_BIT] <= 1'b0;
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= MEM_IDLE;
      endcase
    end
  end

endmodule

// File: doc/memory_access.md
MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 Parameter DMEM_TIMEOUT, default 16: WAIT cycles without dmemAck before the access is aborted.
REQ-002 clk  in  1  single clock; all flops update on the falling edge, matching the rest of the pipeline.
REQ-003 rst  in  1  reset, synchronous, active-low; rst==0 at a clk edge resets the block.
REQ-004 exPc  in  32  PC of the instruction leaving execute.
REQ-005 exAluResult  in  32  ALU result, or the byte address for loads and stores.
REQ-006 exWData  in  32  store data, bypassed rs2.
REQ-007 exMemAccessWidth  in  2  0=byte, 1=half, 2=word; 3 is treated as word.
REQ-008 exIsLoad, exIsStore, exIsLoadUnsigned  in  1 each  memory-op qualifiers.
REQ-009 exRdCtrl  in  7  destination control; bit6 = write enable, other bits carried opaque.
REQ-010 dmemReq, dmemWe  out  1 each  data-memory request and write strobe.
REQ-011 dmemAddr  out  32  word-aligned address, {addr[31:2],2'b00}.
REQ-012 dmemByteEn  out  4  byte-lane enables; dmemWData  out  32  lane-placed store data.
REQ-013 dmemAck  in  1  one-cycle completion; dmemRData  in  32  read word, valid with dmemAck.
REQ-014 stall  out  1  combinational; tells the controller to hold execute and upstream.
REQ-015 misaligned, busError  out  1 each  registered one-cycle exception pulses.
REQ-016 wbPc  out  32, wbRdCtrl  out  7, wbData  out  32  writeback pipe register; wbData also drives the MEM bypass.

Function
REQ-017 FSM states IDLE and WAIT; reset state is IDLE.
REQ-018 Non-memory op in IDLE: wbData<=exAluResult, wbPc/wbRdCtrl<=inputs; 1-cycle latency; stall=0.
REQ-019 Misalignment: half with addr[0]=1, or word with addr[1:0]!=0.
REQ-020 Misaligned op in IDLE: no request; misaligned pulses for 1 cycle; wbRdCtrl bit6<=0; stall=0.
REQ-021 Aligned load/store in IDLE:
  - stall=1 that cycle.
  - at the edge, latch pc, addr, width, data, unsigned flag and rdCtrl; go to WAIT.
REQ-022 In WAIT:
  - dmemReq=1, dmemWe=latched isStore; dmemAddr, dmemByteEn, dmemWData driven from latched fields only.
  - stall=!dmemAck.
  - wbRdCtrl bit6 is 0 (bubble) every WAIT cycle without ack.
REQ-023 Store lane placement:
  - byte: data[7:0] replicated to all lanes, byteEn=1<<addr[1:0].
  - half: data[15:0] replicated, byteEn=addr[1]?1100:0011.
  - word: byteEn=1111.
REQ-024 Load extraction: shift dmemRData right by addr[1:0]*8, take byte or half, sign-extend (unsigned=0) or zero-extend (unsigned=1).
REQ-025 WAIT with dmemAck:
  - register wbPc and wbRdCtrl (latched values); wbData = extracted load data, or latched addr for stores.
  - store wbRdCtrl bit6 forced 0.
  - go to IDLE; stall=0, so upstream advances on the same edge.
REQ-026 Timeout counter clears on entry to WAIT and increments each WAIT cycle without ack.
REQ-027 On reaching DMEM_TIMEOUT without ack: abort, busError pulses 1 cycle, wbRdCtrl bit6<=0, go to IDLE.
REQ-028 dmemAck in the same cycle the count reaches the limit: ack wins; busError stays 0.
REQ-029 dmemAck while IDLE is ignored; dmemReq=0 and dmemWe=0 in IDLE.
REQ-030 Upstream holds inputs stable while stall=1; the block uses only latched fields in WAIT.

Reset
REQ-031 rst==0 (wins over every simultaneous event, including dmemAck and a mid-WAIT access):
  - state IDLE, timeout counter 0.
  - wbPc=0, wbData=0, wbRdCtrl=7'd0.
  - misaligned=0, busError=0; dmemReq=0, dmemWe=0, dmemByteEn=0, dmemAddr=0, dmemWData=0.
REQ-032 An access in flight during reset is dropped with no writeback.

Structure
REQ-033 Shared package holds:
  - MemAccessWidth encodings and the MemState enum.
  - the MemoryAccessStagePipeReg input struct and a WriteBackStagePipeReg output struct.
  - the rdCtrl write-enable bit index.
REQ-034 One sub-module, load_store_aligner, holds the combinational lane placement and load extraction/extension.

Verification
REQ-035 Non-memory op, exAluResult=0x1234, rdCtrl bit6=1 -> next edge wbData=0x1234, stall never 1.
REQ-036 Signed byte load, addr 0x1003, ack after 3 WAIT cycles, rData=0x80xxxxxx:
  - stall=1 for 4 cycles; wbData=0xFFFFFF80.
  - unsigned variant -> wbData=0x00000080.
REQ-037 Half store, addr 0x2002, data 0xABCD -> dmemByteEn=1100, dmemWData=0xABCDABCD, dmemWe=1, wbRdCtrl bit6=0.
REQ-038 Word load, addr 0x3001 -> misaligned pulses 1 cycle, dmemReq never 1, wbRdCtrl bit6=0.
REQ-039 Word load, no ack for 16 WAIT cycles -> busError pulses 1 cycle, state IDLE, no write.
  - ack on the 16th cycle instead -> normal writeback, busError=0.
REQ-040 rst=0 in the second WAIT cycle while dmemAck=1 -> all outputs at reset values next edge, no writeback.
